f1_reaction_timer: RTL and testbench

F1_REACTION_TIMER -- requirements
Module: f1_reaction_timer

---
 rtl/f1_reaction_timer.sv | 113 +++++++++++
 tb/tb_f1_reaction_timer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/f1_reaction_timer.sv
// ---------------------------------------------------------------------------
// f1_reaction_timer
//   Measures driver reaction time from "lights out" to the first button press,
//   in units of an external 1 ms tick strobe.
//
//   Ports
//     clk          system clock, all state updates on its rising edge
//     rst          asynchronous active-high reset
//     lights[7:0]  start-light pattern (8'hFF all on, 8'h00 all off)
//     tick         one-cycle timebase strobe, counted only while timing
//     btn          driver button level, already synchronous to clk
//     react_time   last captured reaction time (ticks), saturates at all-ones
//     valid        one-cycle pulse when react_time is updated
//     false_start  sticky: button pressed before lights out
//     timeout      sticky: counter saturated with no press
//     busy         high while armed or timing (combinational state decode)
// ---------------------------------------------------------------------------
module f1_reaction_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       lights,
    input  logic             tick,
    input  logic             btn,
    output logic [CNT_W-1:0] react_time,
    output logic             valid,
    output logic             false_start,
    output logic             timeout,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        TIMING,
        DONE,
        FAULT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             btn_q;
    logic             press;

    // Rising edge of the button level; a held button never re-triggers.
    assign press = btn & ~btn_q;
    assign busy  = (state == ARMED) || (state == TIMING);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            btn_q       <= 1'b0;
            react_time  <= '0;
            valid       <= 1'b0;
            false_start <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            btn_q <= btn;
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (lights == 8'hFF) begin
                        state       <= ARMED;
                        false_start <= 1'b0;
                        timeout     <= 1'b0;
                    end
                end
                ARMED: begin
                    // A press wins over a simultaneous lights-out.
                    if (press) begin
                        state       <= FAULT;
                        false_start <= 1'b1;
                    end else if (lights == 8'h00) begin
                        state <= TIMING;
                        cnt   <= '0;
                    end
                end
                TIMING: begin
                    if (press) begin
                        // Capture the count as it stood before this cycle's tick.
                        react_time <= cnt;
                        valid      <= 1'b1;
                        state      <= DONE;
                    end else if (cnt == CNT_MAX) begin
                        react_time <= CNT_MAX;
                        timeout    <= 1'b1;
                        valid      <= 1'b1;
                        state      <= DONE;
                    end else if (tick) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                FAULT: begin
                    if (lights == 8'h00) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_f1_reaction_timer.sv
// ---------------------------------------------------------------------------
// tb_f1_reaction_timer
//   Runs a 16-bit and a 4-bit instance side by side on the same stimulus.
//   A behavioural model per instance predicts every output and is compared
//   on each falling edge; directed literal checks pin the key scenarios.
// ---------------------------------------------------------------------------
module tb_f1_reaction_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] lights = 8'h00;
    logic       tick = 1'b0;
    logic       btn = 1'b0;

    logic [15:0] rt16;
    logic        v16, fs16, to16, b16;
    logic [3:0]  rt4;
    logic        v4, fs4, to4, b4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    f1_reaction_timer #(.CNT_W(16)) dut16 (
        .clk(clk), .rst(rst), .lights(lights), .tick(tick), .btn(btn),
        .react_time(rt16), .valid(v16), .false_start(fs16), .timeout(to16), .busy(b16)
    );

    f1_reaction_timer #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .lights(lights), .tick(tick), .btn(btn),
        .react_time(rt4), .valid(v4), .false_start(fs4), .timeout(to4), .busy(b4)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase: 0 waiting for all-on, 1 lights on, 2 measuring, 3 reporting, 4 jumped start.
    int m_ph[2], m_el[2], m_rt[2];
    bit m_v[2], m_fs[2], m_to[2];
    bit m_bprev;
    int m_max[2] = '{65535, 15};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_ph[i] <= 0; m_el[i] <= 0; m_rt[i] <= 0;
                m_v[i] <= 0; m_fs[i] <= 0; m_to[i] <= 0;
            end
            m_bprev <= 0;
        end else begin
            m_bprev <= btn;
            for (int i = 0; i < 2; i++) begin
                m_v[i] <= 0;
                case (m_ph[i])
                    0: if (lights == 8'hFF) begin
                        m_ph[i] <= 1; m_fs[i] <= 0; m_to[i] <= 0;
                    end
                    1: if (btn && !m_bprev) begin
                        m_ph[i] <= 4; m_fs[i] <= 1;
                    end else if (lights == 8'h00) begin
                        m_ph[i] <= 2; m_el[i] <= 0;
                    end
                    2: if (btn && !m_bprev) begin
                        m_rt[i] <= m_el[i]; m_v[i] <= 1; m_ph[i] <= 3;
                    end else if (m_el[i] == m_max[i]) begin
                        m_rt[i] <= m_max[i]; m_to[i] <= 1; m_v[i] <= 1; m_ph[i] <= 3;
                    end else if (tick) begin
                        m_el[i] <= m_el[i] + 1;
                    end
                    3: m_ph[i] <= 0;
                    default: if (lights == 8'h00) m_ph[i] <= 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        chk("m16_rt", int'(rt16), m_rt[0]);
        chk("m16_valid", int'(v16), int'(m_v[0]));
        chk("m16_fs", int'(fs16), int'(m_fs[0]));
        chk("m16_to", int'(to16), int'(m_to[0]));
        chk("m16_busy", int'(b16), int'(m_ph[0] == 1 || m_ph[0] == 2));
        chk("m4_rt", int'(rt4), m_rt[1]);
        chk("m4_valid", int'(v4), int'(m_v[1]));
        chk("m4_fs", int'(fs4), int'(m_fs[1]));
        chk("m4_to", int'(to4), int'(m_to[1]));
        chk("m4_busy", int'(b4), int'(m_ph[1] == 1 || m_ph[1] == 2));
    end

    // Apply inputs for one cycle; returns at the falling edge after they were sampled.
    task automatic cyc(input logic [7:0] l, input logic t, input logic b);
        lights = l; tick = t; btn = b;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) cyc(8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        logic [7:0] l;
        bit seen;
        // Reset
        repeat (2) @(negedge clk);
        chk("rst_rt", int'(rt16), 0);
        chk("rst_busy", int'(b16), 0);
        rst = 1'b0;

        // Normal run: lights fill up, go out, 37 ticks, press
        l = 8'h00;
        for (int k = 0; k < 9; k++) begin
            cyc(l, 1'b0, 1'b0);
            l = {l[6:0], 1'b1};
        end
        chk("t1_armed_busy", int'(b16), 1);
        cyc(8'h00, 1'b0, 1'b0);
        ticks(37);
        cyc(8'h00, 1'b0, 1'b1);
        chk("t1_rt", int'(rt16), 37);
        chk("t1_valid", int'(v16), 1);
        chk("t1_fs", int'(fs16), 0);
        chk("t1_to", int'(to16), 0);
        cyc(8'h00, 1'b0, 1'b0);
        chk("t1_valid_off", int'(v16), 0);
        chk("t1_busy_off", int'(b16), 0);

        // False start while lights all on
        cyc(8'hFF, 1'b0, 1'b0);
        cyc(8'hFF, 1'b0, 1'b1);
        chk("t2_fs", int'(fs16), 1);
        chk("t2_valid", int'(v16), 0);
        chk("t2_rt_kept", int'(rt16), 37);
        cyc(8'hFF, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'hFF, 1'b0, 1'b0);
        chk("t2_fs_cleared", int'(fs16), 0);
        chk("t2_rearmed", int'(b16), 1);

        // Press on the same cycle lights go out
        cyc(8'h00, 1'b0, 1'b1);
        chk("t3_fs", int'(fs16), 1);
        chk("t3_rt_kept", int'(rt16), 37);
        chk("t3_busy", int'(b16), 0);
        cyc(8'h00, 1'b0, 1'b0);

        // Tick and press together at count 5
        cyc(8'hFF, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        ticks(5);
        cyc(8'h00, 1'b1, 1'b1);
        chk("t4_rt16", int'(rt16), 5);
        chk("t4_rt4", int'(rt4), 5);
        chk("t4_valid", int'(v16), 1);
        cyc(8'h00, 1'b0, 1'b0);

        // Timeout on the 4-bit instance
        cyc(8'hFF, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        ticks(15);
        seen = 0;
        for (int k = 0; k < 6 && !seen; k++) begin
            cyc(8'h00, 1'b0, 1'b0);
            if (v4) seen = 1;
        end
        chk("t5_valid_seen", int'(seen), 1);
        chk("t5_rt4", int'(rt4), 15);
        chk("t5_to4", int'(to4), 1);
        cyc(8'h00, 1'b0, 1'b1);  // finish the 16-bit run at 15
        chk("t5_rt16", int'(rt16), 15);
        cyc(8'h00, 1'b0, 1'b0);

        // Press in the saturation cycle: a press, not a timeout
        cyc(8'hFF, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        ticks(15);
        cyc(8'h00, 1'b0, 1'b1);
        chk("t6_rt4", int'(rt4), 15);
        chk("t6_to4", int'(to4), 0);
        chk("t6_valid4", int'(v4), 1);
        cyc(8'h00, 1'b0, 1'b0);

        // Asynchronous reset mid-run at count 20
        cyc(8'hFF, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        ticks(20);
        tick = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t7_rt", int'(rt16), 0);
        chk("t7_valid", int'(v16), 0);
        chk("t7_fs", int'(fs16), 0);
        chk("t7_to", int'(to16), 0);
        chk("t7_busy", int'(b16), 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(8'h00, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b0);
        chk("t7_idle", int'(b16), 0);
        cyc(8'hFF, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        ticks(8);
        cyc(8'h00, 1'b0, 1'b1);
        chk("t7_rt_after", int'(rt16), 8);
        chk("t7_valid_after", int'(v16), 1);
        cyc(8'h00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
